// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register: takes a WIDTH-bit word over a
// valid/ready handshake and streams it out on sout one bit per enabled clock.
module piso_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             sout_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             sout_last_q, sout_last_d;
  logic             at_last;
  logic             accept;

  assign at_last    = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_ready = en && ((state_q == IDLE) || at_last);
  assign accept     = load_valid && load_ready;

  // Next-state logic; with en low everything simply holds its value.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (en) begin
      if (accept) begin
        state_d = SHIFT;
        shreg_d = load_data;
        cnt_d   = '0;
      end else if (state_q == SHIFT) begin
        if (at_last) begin
          state_d = IDLE;
        end else begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d   = cnt_q + 1'b1;
        end
      end
    end
  end

  // Outputs are precomputed from the next state so they come straight off flops.
  always_comb begin
    sout_valid_d  = (state_d == SHIFT);
    sout_d        = 1'b0;
    if (state_d == SHIFT) begin
      sout_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    end
    frame_start_d = (state_d == SHIFT) && (cnt_d == '0);
    sout_last_d   = (state_d == SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sout_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      sout_last_q   <= sout_last_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign sout_last   = sout_last_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register: an MSB-first and an LSB-first
// instance driven from the same inputs, checked against hand-computed bits.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load_valid;
  logic [7:0] load_data;

  logic load_ready, sout, sout_valid, frame_start, sout_last;
  logic l_load_ready, l_sout, l_sout_valid, l_frame_start, l_sout_last;

  int total = 0;
  int bad   = 0;

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .sout(sout),
    .sout_valid(sout_valid), .frame_start(frame_start), .sout_last(sout_last)
  );

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .en(en), .load_valid(load_valid),
    .load_data(load_data), .load_ready(l_load_ready), .sout(l_sout),
    .sout_valid(l_sout_valid), .frame_start(l_frame_start), .sout_last(l_sout_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v, input logic [7:0] d);
    reset      = r;
    en         = e;
    load_valid = v;
    load_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks the MSB-first instance while bit idx (0 = first) of word is on sout.
  task automatic expectBit(input string tag, input logic [7:0] word, input int idx);
    logic [7:0] w;
    w = word;
    checkOutput({tag, "_sout"},  32'(sout), 32'(w[7-idx]));
    checkOutput({tag, "_valid"}, 32'(sout_valid), 32'd1);
    checkOutput({tag, "_start"}, 32'(frame_start), 32'(idx == 0));
    checkOutput({tag, "_last"},  32'(sout_last), 32'(idx == 7));
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, "_idle_sout"},  32'(sout), 32'd0);
    checkOutput({tag, "_idle_valid"}, 32'(sout_valid), 32'd0);
    checkOutput({tag, "_idle_last"},  32'(sout_last), 32'd0);
  endtask

  initial begin
    logic [7:0] w;

    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    step();
    step();
    expectIdle("rst");
    checkOutput("rst_start", 32'(frame_start), 32'd0);
    checkOutput("rst_ready_en", 32'(load_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("rst_ready_noen", 32'(load_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // T1: MSB-first 0xA5
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      expectBit("t1", 8'hA5, i);
      checkOutput("t1_ready", 32'(load_ready), 32'(i == 7));
      step();
    end
    expectIdle("t1");

    // T2: LSB-first 0x0F
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    w = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_sout",  32'(l_sout), 32'(w[i]));
      checkOutput("t2_start", 32'(l_frame_start), 32'(i == 0));
      checkOutput("t2_last",  32'(l_sout_last), 32'(i == 7));
      checkOutput("t2_ready", 32'(l_load_ready), 32'(i == 7));
      step();
    end
    checkOutput("t2_valid_end", 32'(l_sout_valid), 32'd0);
    checkOutput("t2_sout_end",  32'(l_sout), 32'd0);

    // T3: back-to-back 0x0F then 0xF0 with no gap
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      expectBit("t3a", 8'h0F, i);
      if (i == 7) applyStimulus(1'b0, 1'b1, 1'b1, 8'hF0);
      step();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      expectBit("t3b", 8'hF0, i);
      step();
    end
    expectIdle("t3");

    // T4: three-cycle stall after bit 3 of 0xA5
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      expectBit("t4a", 8'hA5, i);
      if (i < 2) step();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    for (int s = 0; s < 3; s++) begin
      step();
      checkOutput("t4_stall_sout",  32'(sout), 32'd1);
      checkOutput("t4_stall_valid", 32'(sout_valid), 32'd1);
      checkOutput("t4_stall_ready", 32'(load_ready), 32'd0);
      checkOutput("t4_stall_last",  32'(sout_last), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    for (int i = 3; i < 8; i++) begin
      expectBit("t4b", 8'hA5, i);
      step();
    end
    expectIdle("t4");

    // T5: reset during bit 4 aborts the frame
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      expectBit("t5a", 8'hA5, i);
      if (i < 3) step();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    expectIdle("t5");
    checkOutput("t5_ready", 32'(load_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      expectBit("t5b", 8'h3C, i);
      step();
    end
    expectIdle("t5end");

    // T6: early load_valid of 0xFF is held off until the last bit of 0x00
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      expectBit("t6a", 8'h00, i);
      checkOutput("t6_ready", 32'(load_ready), 32'(i == 7));
      if (i == 0) applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
      step();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      expectBit("t6b", 8'hFF, i);
      step();
    end
    expectIdle("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
